data_stack: RTL
===============

DATA_STACK -- requirements
Module: data_stack

Interface
REQ-001 SHALL have parameter WIDTH, default 16, meaning cell width in bits.
REQ-002 SHALL have parameter DEPTH, default 16, meaning maximum number of cells held, including TOS and NOS.
REQ-003 SHALL have port c_YCLOCK, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port c_RESET, input, 1 bit: reset, asynchronous and active-high.
REQ-005 SHALL have port f_stackctrl, input, 3 bits: operation select, encodings per REQ-011.
REQ-006 SHALL have port i_DATA, input, WIDTH bits: value for PUSH, and result for UNARY and BINARY.
REQ-007 SHALL have port f_clrerr, input, 1 bit: clears the sticky error flags.
REQ-008 SHALL have ports o_TOS and o_NOS, output, WIDTH bits each: top and second cell, fed to the ALU operands.
REQ-009 SHALL have port o_DEPTH, output, 5 bits: current cell count, 0..DEPTH.
REQ-010 SHALL have ports o_EMPTY, o_FULL, o_OVERFLOW and o_UNDERFLOW, output, 1 bit each: status flags.

Function
REQ-011 SHALL decode f_stackctrl as follows:
- 000 NOP.
- 001 PUSH i_DATA.
- 010 DROP.
- 011 UNARY: TOS<=i_DATA, depth unchanged.
- 100 BINARY: pop two cells, push i_DATA; depth-1.
- 101 DUP.
- 110 SWAP.
- 111 OVER.
REQ-012 SHALL hold TOS and NOS in registers and keep cells 3..DEPTH in a spill memory indexed by a pointer.
REQ-013 SHALL make every operation single-cycle: o_TOS, o_NOS and o_DEPTH reflect the result on the edge after the op is presented.
REQ-014 SHALL require a minimum depth per operation, else underflow:
- DROP, UNARY, DUP: 1.
- BINARY, SWAP, OVER: 2.
REQ-015 SHALL treat PUSH, DUP and OVER at depth==DEPTH as overflow.
REQ-016 SHALL handle an underflow or overflow op as follows:
- no change to cells or depth;
- set the matching sticky flag;
- flag asserted from the next cycle.
REQ-017 SHALL drive o_TOS to 0 when depth<1 and o_NOS to 0 when depth<2.
REQ-018 SHALL assert o_EMPTY combinationally when depth==0, and o_FULL when depth==DEPTH.
REQ-019 SHALL, when f_clrerr is high, clear both sticky flags that cycle; f_clrerr takes priority over a simultaneous error set.
REQ-020 SHALL spill NOS into memory on net push (PUSH, DUP, OVER) when depth>=2.
REQ-021 SHALL refill NOS from memory on net pop (DROP, BINARY) when depth>=3.
REQ-022 SHALL, for SWAP, exchange TOS and NOS with the memory untouched.
REQ-023 SHALL, for OVER, push the old NOS, leaving NOS equal to the old TOS.
REQ-024 SHALL keep the spill pointer consistent with depth: pointer = max(depth-2, 0).

Reset
REQ-025 SHALL, while c_RESET is high, asynchronously set:
- depth to 0;
- TOS, NOS and the pointer to 0;
- o_OVERFLOW and o_UNDERFLOW to 0.
REQ-026 SHALL treat reset mid-sequence as discarding all stacked contents; spill memory contents need not be cleared.
REQ-027 SHALL, on the first edge after reset deasserts, honour f_stackctrl normally.

Structure
REQ-028 SHALL take the opcode constants, WIDTH and DEPTH defaults from a shared package (stack_pkg) also used by the control unit.
REQ-029 SHALL place the spill memory in sub-module stack_ram:
- DEPTH-2 entries;
- synchronous write;
- asynchronous read.

Verification
REQ-030 SHALL cover: reset; PUSH 5, PUSH 7 -> o_TOS=7, o_NOS=5, o_DEPTH=2.
REQ-031 SHALL cover:
- PUSH 1,2,3, then BINARY with i_DATA=5 -> o_TOS=5, o_NOS=1, o_DEPTH=2;
- then DROP -> o_TOS=1.
REQ-032 SHALL cover PUSH 16 values 0..15:
- o_FULL=1;
- a 17th PUSH -> o_OVERFLOW=1, o_TOS=15, depth 16;
- 16 DROPs -> o_EMPTY=1.
REQ-033 SHALL cover:
- empty stack, DROP -> o_UNDERFLOW=1, depth 0;
- f_clrerr -> flag 0;
- depth 1, BINARY -> underflow, TOS kept.
REQ-034 SHALL cover:
- PUSH 3, PUSH 4, SWAP -> TOS 3, NOS 4;
- OVER -> TOS 4, NOS 3, depth 3;
- DUP -> depth 4, TOS 4.
REQ-035 SHALL cover reset asserted mid-sequence at depth 5 -> o_DEPTH=0, o_TOS=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/stack_pkg.sv
// Shared definitions for the data stack and the control unit that drives it:
// opcode encoding, default geometry and per-opcode depth rules.
package stack_pkg;

    localparam int WIDTH_DEF = 16;
    localparam int DEPTH_DEF = 16;
    localparam int DEPTH_W   = 5;

    typedef enum logic [2:0] {
        OP_NOP    = 3'b000,
        OP_PUSH   = 3'b001,
        OP_DROP   = 3'b010,
        OP_UNARY  = 3'b011,
        OP_BINARY = 3'b100,
        OP_DUP    = 3'b101,
        OP_SWAP   = 3'b110,
        OP_OVER   = 3'b111
    } stack_op_e;

    function automatic logic [DEPTH_W-1:0] min_depth(stack_op_e op);
        case (op)
            OP_DROP, OP_UNARY, OP_DUP:  return DEPTH_W'(1);
            OP_BINARY, OP_SWAP, OP_OVER: return DEPTH_W'(2);
            default:                     return '0;
        endcase
    endfunction

    function automatic logic is_net_push(stack_op_e op);
        return (op == OP_PUSH) || (op == OP_DUP) || (op == OP_OVER);
    endfunction

    function automatic logic is_net_pop(stack_op_e op);
        return (op == OP_DROP) || (op == OP_BINARY);
    endfunction

endpackage

// File: rtl/stack_ram.sv
// Spill memory for cells below NOS: synchronous write, asynchronous read.
module stack_ram #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic             c_YCLOCK,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] mem [DEPTH-2];

    always_ff @(posedge c_YCLOCK) begin
        if (wr_en) mem[wr_addr] <= wr_data;
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/data_stack.sv
// Hardware data stack: TOS/NOS in registers, deeper cells spilled to stack_ram.
// Every opcode completes in one cycle; illegal ops leave the stack intact and raise a sticky flag.
module data_stack
    import stack_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic               c_YCLOCK,
    input  logic               c_RESET,
    input  logic [2:0]         f_stackctrl,
    input  logic [WIDTH-1:0]   i_DATA,
    input  logic               f_clrerr,
    output logic [WIDTH-1:0]   o_TOS,
    output logic [WIDTH-1:0]   o_NOS,
    output logic [DEPTH_W-1:0] o_DEPTH,
    output logic               o_EMPTY,
    output logic               o_FULL,
    output logic               o_OVERFLOW,
    output logic               o_UNDERFLOW
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [DEPTH_W-1:0] DEPTH_MAX = DEPTH_W'(DEPTH);

    stack_op_e          op;
    logic [WIDTH-1:0]   tos_q, tos_nx, nos_q, nos_nx;
    logic [DEPTH_W-1:0] depth_q, depth_nx;
    logic [AW-1:0]      ptr_q, ptr_nx, rd_addr;
    logic [WIDTH-1:0]   rd_data, refill;
    logic               ovf_q, unf_q, ovf_set, unf_set, spill_we, full;

    assign op      = stack_op_e'(f_stackctrl);
    assign full    = (depth_q == DEPTH_MAX);
    assign rd_addr = (ptr_q == '0) ? '0 : ptr_q - AW'(1);
    assign refill  = (depth_q >= DEPTH_W'(3)) ? rd_data : '0;

    stack_ram #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW)) u_ram (
        .c_YCLOCK (c_YCLOCK),
        .wr_en    (spill_we),
        .wr_addr  (ptr_q),
        .wr_data  (nos_q),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data)
    );

    always_comb begin
        tos_nx   = tos_q;
        nos_nx   = nos_q;
        depth_nx = depth_q;
        ptr_nx   = ptr_q;
        spill_we = 1'b0;
        ovf_set  = 1'b0;
        unf_set  = 1'b0;
        if (depth_q < min_depth(op)) begin
            unf_set = 1'b1;
        end else if (is_net_push(op) && full) begin
            ovf_set = 1'b1;
        end else begin
            case (op)
                OP_PUSH:   begin tos_nx = i_DATA; nos_nx = tos_q;  end
                OP_DROP:   begin tos_nx = nos_q;  nos_nx = refill; end
                OP_UNARY:  tos_nx = i_DATA;
                OP_BINARY: begin tos_nx = i_DATA; nos_nx = refill; end
                OP_DUP:    nos_nx = tos_q;
                OP_SWAP, OP_OVER: begin tos_nx = nos_q; nos_nx = tos_q; end
                default: ;
            endcase
            // Old NOS goes to memory on growth; OVER therefore spills exactly the cell it copies.
            if (is_net_push(op)) begin
                depth_nx = depth_q + DEPTH_W'(1);
                if (depth_q >= DEPTH_W'(2)) begin
                    spill_we = 1'b1;
                    ptr_nx   = ptr_q + AW'(1);
                end
            end else if (is_net_pop(op)) begin
                depth_nx = depth_q - DEPTH_W'(1);
                if (depth_q >= DEPTH_W'(3)) ptr_nx = ptr_q - AW'(1);
            end
        end
    end

    always_ff @(posedge c_YCLOCK or posedge c_RESET) begin
        if (c_RESET) begin
            tos_q   <= '0;
            nos_q   <= '0;
            depth_q <= '0;
            ptr_q   <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            tos_q   <= tos_nx;
            nos_q   <= nos_nx;
            depth_q <= depth_nx;
            ptr_q   <= ptr_nx;
            if (f_clrerr) begin
                ovf_q <= 1'b0;
                unf_q <= 1'b0;
            end else begin
                ovf_q <= ovf_q | ovf_set;
                unf_q <= unf_q | unf_set;
            end
        end
    end

    assign o_TOS       = (depth_q >= DEPTH_W'(1)) ? tos_q : '0;
    assign o_NOS       = (depth_q >= DEPTH_W'(2)) ? nos_q : '0;
    assign o_DEPTH     = depth_q;
    assign o_EMPTY     = (depth_q == '0);
    assign o_FULL      = full;
    assign o_OVERFLOW  = ovf_q;
    assign o_UNDERFLOW = unf_q;

endmodule
